// File: rtl/dsp_seq_mac.sv
// dsp_seq_mac: iterative multi-precision MAC, out = aa*bb + addend, one SLICE^2 multiplier.
// Build option DSP_ACC_SAT_EN: saturate the accumulator on carry out instead of wrapping.
module dsp_seq_mac #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SLICE      = 16,
    parameter int unsigned GUARD      = 0,
    parameter int unsigned SHIFT_BITS = 2,
    localparam int unsigned ACC_W     = 2 * WIDTH + GUARD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            mode,
    input  logic                  mac,
    input  logic [SHIFT_BITS-1:0] shift_amount,
    input  logic                  shift_dir,
    input  logic [WIDTH-1:0]      aa,
    input  logic [WIDTH-1:0]      bb,
    input  logic [ACC_W-1:0]      cc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out,
    output logic                  ovf
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * SLICE;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t           state;
    logic             run;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       mode_r;
    logic [IW-1:0]    i_idx;
    logic [IW-1:0]    j_idx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prev;
    logic             acc_ovf;

    logic             accept;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] init;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] pp;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_nxt;
    logic             last;

    assign in_ready = run & ((state == S_IDLE) |
                             ((state == S_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    // A request taken on the delivery edge chains off the result in flight.
    assign base = (state == S_DONE) ? out : prev;
    assign init = mac ? (shift_dir ? (base >> shift_amount)
                                   : (base << shift_amount))
                      : cc;

    always_comb begin
        a_sl  = a_r[int'(i_idx) * SLICE +: SLICE];
        b_sl  = b_r[int'(j_idx) * SLICE +: SLICE];
        prod  = PW'(a_sl) * PW'(b_sl);
        pp    = ACC_W'(prod) << ((int'(i_idx) + int'(j_idx)) * SLICE);
        if (mode_r == 2'd3) begin
            pp = '0;
        end
        sum   = {1'b0, acc} + {1'b0, pp};
        carry = sum[ACC_W];
`ifdef DSP_ACC_SAT_EN
        acc_nxt = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
    end

    always_comb begin
        last = 1'b1;
        unique case (mode_r)
            2'd1:    last = (i_idx == LAST);
            2'd2:    last = (i_idx == LAST) && (j_idx == LAST);
            default: last = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            run       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            mode_r    <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            acc       <= '0;
            prev      <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
        end else begin
            run <= 1'b1;
            unique case (state)
                S_IDLE: begin
                end
                S_MUL: begin
                    acc     <= acc_nxt;
                    acc_ovf <= acc_ovf | carry;
                    if (last) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        out       <= acc_nxt;
                        ovf       <= acc_ovf | carry;
                    end else if (mode_r == 2'd2 && j_idx != LAST) begin
                        j_idx <= j_idx + 1'b1;
                    end else begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        prev      <= out;
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Mode 3 still spends one MUL cycle (adding zero) to keep latency >= 1.
            if (accept) begin
                state   <= S_MUL;
                a_r     <= aa;
                b_r     <= bb;
                mode_r  <= mode;
                i_idx   <= '0;
                j_idx   <= '0;
                acc     <= init;
                acc_ovf <= 1'b0;
                ovf     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_seq_mac.sv
// tb_dsp_seq_mac: directed vectors for dsp_seq_mac (WIDTH=32, SLICE=16).
// Expected values are hand-computed constants.
module tb_dsp_seq_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mode = '0;
    logic        mac = 1'b0;
    logic [1:0]  shift_amount = '0;
    logic        shift_dir = 1'b0;
    logic [31:0] aa = '0;
    logic [31:0] bb = '0;
    logic [63:0] cc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out;
    logic        ovf;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dsp_seq_mac #(
        .WIDTH(32),
        .SLICE(16),
        .GUARD(0),
        .SHIFT_BITS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mode(mode),
        .mac(mac),
        .shift_amount(shift_amount),
        .shift_dir(shift_dir),
        .aa(aa),
        .bb(bb),
        .cc(cc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .ovf(ovf)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [1:0] m, input logic mc,
                         input logic [1:0] sa, input logic sd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] c);
        mode = m;
        mac = mc;
        shift_amount = sa;
        shift_dir = sd;
        aa = a;
        bb = b;
        cc = c;
        in_valid = 1'b1;
    endtask

    // Waits for the accept edge, then scrambles inputs to prove capture.
    task automatic accept_wait(input string tag);
        int k = 0;
        #1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        aa = '1;
        bb = '1;
        cc = '1;
        mac = 1'b1;
        shift_amount = 2'd3;
        mode = 2'd2;
    endtask

    task automatic wait_result(input string tag, input int lat,
                               input logic [63:0] eo, input logic eovf);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_out"}, out, eo);
        check({tag, "_ovf"}, 64'(ovf), 64'(eovf));
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_fall"}, 64'(out_valid), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [1:0] m,
                         input logic mc, input logic [1:0] sa,
                         input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] c,
                         input int lat, input logic [63:0] eo,
                         input logic eovf);
        @(negedge clk);
        start(m, mc, sa, sd, a, b, c);
        accept_wait(tag);
        wait_result(tag, lat, eo, eovf);
        take(tag);
    endtask

    initial begin
        logic [63:0] hold;
        logic        seen;
        logic [63:0] sat_exp;

        // reset state
        #12;
        check("rst_rdy", 64'(in_ready), 64'd0);
        check("rst_vld", 64'(out_valid), 64'd0);
        check("rst_out", out, 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_rdy", 64'(in_ready), 64'd1);

        do_op("t1", 2'd0, 1'b0, 2'd0, 1'b0, 32'd3, 32'd5, 64'd7,
              1, 64'd22, 1'b0);
        do_op("t2", 2'd2, 1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 64'd0, 4, 64'hFFFF_FFFE_0000_0001, 1'b0);
        do_op("t2b", 2'd2, 1'b0, 2'd0, 1'b0, 32'h0002_0003,
              32'h0004_0005, 64'd0, 4, 64'h0000_0008_0016_000F, 1'b0);

        // chained accumulate
        do_op("t3a", 2'd0, 1'b0, 2'd0, 1'b0, 32'd2, 32'd3, 64'd0,
              1, 64'd6, 1'b0);
        do_op("t3b", 2'd0, 1'b1, 2'd1, 1'b0, 32'd1, 32'd1, 64'hAA,
              1, 64'd13, 1'b0);
        do_op("t3c", 2'd3, 1'b1, 2'd2, 1'b1, 32'd9, 32'd9, 64'hAA,
              1, 64'd3, 1'b0);

        // backpressure, then accept on the delivery edge
        @(negedge clk);
        start(2'd1, 1'b0, 2'd0, 1'b0, 32'h1234_5678, 32'hABCD_0003,
              64'd1);
        accept_wait("t4");
        wait_result("t4", 2, 64'h0000_0000_369D_0369, 1'b0);
        hold = out;
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_out", out, hold);
            check("t4_hold_ovf", 64'(ovf), 64'd0);
            check("t4_hold_vld", 64'(out_valid), 64'd1);
            check("t4_hold_rdy", 64'(in_ready), 64'd0);
        end
        start(2'd0, 1'b1, 2'd0, 1'b0, 32'd2, 32'd2, 64'hAA);
        out_ready = 1'b1;
        #1;
        check("t4_rdy_same", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t4_fall", 64'(out_valid), 64'd0);
        wait_result("t4b", 1, 64'h0000_0000_369D_036D, 1'b0);
        take("t4b");

        // reset during the second MUL cycle
        @(negedge clk);
        start(2'd2, 1'b0, 2'd0, 1'b0, 32'd5, 32'd7, 64'd0);
        accept_wait("t5");
        check("t5_busy", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_vld", 64'(out_valid), 64'd0);
        check("t5_rdy", 64'(in_ready), 64'd0);
        check("t5_out", out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("t5_novld", 64'(seen), 64'd0);
        do_op("t5b", 2'd0, 1'b1, 2'd0, 1'b0, 32'd1, 32'd1, 64'hFF,
              1, 64'd1, 1'b0);

        // overflow
`ifdef DSP_ACC_SAT_EN
        sat_exp = '1;
`else
        sat_exp = '0;
`endif
        do_op("t6", 2'd0, 1'b0, 2'd0, 1'b0, 32'd1, 32'd1, '1,
              1, sat_exp, 1'b1);
        do_op("t7", 2'd0, 1'b0, 2'd0, 1'b0, 32'd3, 32'd5, 64'd7,
              1, 64'd22, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
